// File: rtl/ram_rd_stream_pkg.sv
// ram_rd_stream_pkg
// Shared types and constants for the RAM read-stream sequencer.
//   state_t    : sequencer FSM encoding (IDLE, ISSUE, DRAIN, FLUSH)
//   RD_LAT_MIN : smallest supported RAM read latency
//   RD_LAT_MAX : largest supported RAM read latency
//   fifo_depth : output buffer depth needed for a given read latency
package ram_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // One slot per read that can be in flight plus one for the head beat
  // waiting on the consumer.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/ram_rd_stream_fifo.sv
// ram_rd_stream_fifo
// Small synchronous FIFO carrying a data word plus a last-beat flag.
// A push and a pop in the same cycle are accepted even when full; a pop
// while empty is ignored.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_data,
//   push_last             : write side
//   pop                   : read side, advances the head
//   head_data, head_last  : current head entry (head_last forced 0 when empty)
//   count, full, empty    : occupancy status
module ram_rd_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] last_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = data_mem[rd_ptr];
  assign head_last = last_mem[rd_ptr] && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_mem <= '0;
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_rd_stream.sv
// ram_rd_stream
// Read-side sequencer for the simple dual-port RAM wrapper. A start command
// walks start_addr .. start_addr+len-1 (modulo 2^ADDR_WIDTH) on the RAM read
// port, absorbs the RAM read latency and returns the words as a stream.
//
// Stream handshake: a beat transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is high, m_data/m_last hold until the
// transfer; m_valid never drops without a transfer (except on reset).
//
// Optional build macro RAM_RD_STREAM_STALL_CNT_EN adds stall_cnt, a saturating
// count of m_valid && !m_ready cycles, cleared on each accepted start.
//
// Ports:
//   rd_clk, rd_rst_n : clock (also the RAM read clock), async active-low reset
//   start            : command strobe, sampled only when idle
//   start_addr, len  : first address and beat count (0..2^ADDR_WIDTH)
//   busy, done       : command in progress / one-cycle completion pulse
//   ram_rd_addr      : registered RAM read address
//   ram_rd_data      : RAM read data, RD_LATENCY cycles after the address
//   m_valid, m_ready,
//   m_data, m_last   : output stream
//   stall_cnt        : (optional) backpressure cycle counter
module ram_rd_stream
  import ram_rd_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef RAM_RD_STREAM_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 1;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("ram_rd_stream: RD_LATENCY must be 1 or 2");
  end

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] remain;
  logic [RD_LATENCY:1] lat_valid;
  logic [RD_LATENCY:1] lat_last;
  logic                issue;
  logic                issue_last;
  logic                start_ok;
  logic                pop;
  logic                credit_ok;
  logic [OW-1:0]       inflight;
  logic [OW-1:0]       owned;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                done_q;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign busy    = (state != ST_IDLE);
  assign done    = done_q;

  // Every issued read owns a FIFO slot from issue until it leaves the head.
  // The beat leaving this cycle frees its slot for a read issued this cycle,
  // which keeps one beat per cycle under continuous m_ready.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LATENCY; k++) inflight = inflight + OW'(lat_valid[k]);
    owned     = inflight + OW'(fifo_count) - OW'(pop);
    credit_ok = (owned < OW'(DEPTH));
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (len == '0) ? ST_FLUSH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remain == (ADDR_WIDTH + 1)'(1)) begin
            issue_last = 1'b1;
            state_nxt  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) state_nxt = ST_IDLE;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state       <= ST_IDLE;
      remain      <= '0;
      ram_rd_addr <= '0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= ((state == ST_DRAIN) || (state == ST_FLUSH)) && (state_nxt == ST_IDLE);
      if (start_ok) begin
        remain      <= len;
        ram_rd_addr <= start_addr;
      end else if (issue) begin
        remain <= remain - (ADDR_WIDTH + 1)'(1);
        // The final address stays on the port after the burst.
        if (!issue_last) ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Stage k is high in the k-th cycle after an issue; the last stage lines
  // up with the RAM presenting that read's data.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      lat_valid <= '0;
      lat_last  <= '0;
    end else begin
      lat_valid[1] <= issue;
      lat_last[1]  <= issue_last;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        lat_valid[k] <= lat_valid[k-1];
        lat_last[k]  <= lat_last[k-1];
      end
    end
  end

  ram_rd_stream_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (lat_valid[RD_LATENCY]),
    .push_data (ram_rd_data),
    .push_last (lat_last[RD_LATENCY]),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(lat_valid[RD_LATENCY] && fifo_full && !pop));

`ifdef RAM_RD_STREAM_STALL_CNT_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb_ram_rd_stream
// Bench for ram_rd_stream. Two instances share clock and reset: g_dut[0]
// with RD_LATENCY=1 and g_dut[1] with RD_LATENCY=2, each with its own RAM
// model preloaded with mem[i] = i[7:0]. Commands go to one instance at a time
// (sel); expected beats are queued when a command is driven and compared when
// the selected instance hands a beat over.
// Build macro RAM_RD_STREAM_STALL_CNT_EN enables the stall counter checks.
module tb_ram_rd_stream;

  localparam int AW = 10;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]         start_v;
  logic [AW-1:0]      start_addr;
  logic [AW:0]        len;
  logic [1:0]         m_ready_v;
  logic [1:0]         busy_v;
  logic [1:0]         done_v;
  logic [1:0]         m_valid_v;
  logic [1:0]         m_last_v;
  logic [1:0][AW-1:0] rd_addr_v;
  logic [1:0][DW-1:0] rd_data_v;
  logic [1:0][DW-1:0] m_data_v;
`ifdef RAM_RD_STREAM_STALL_CNT_EN
  logic [1:0][15:0]   stall_v;
`endif

  logic [DW-1:0] mem [1 << AW];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] pipe [g + 1];
    always @(posedge clk) begin
      pipe[0] <= mem[rd_addr_v[g]];
      for (int k = 1; k < g + 1; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_data_v[g] = pipe[g];

    ram_rd_stream #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (g + 1)
    ) u_dut (
      .rd_clk      (clk),
      .rd_rst_n    (rst_n),
      .start       (start_v[g]),
      .start_addr  (start_addr),
      .len         (len),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .ram_rd_addr (rd_addr_v[g]),
      .ram_rd_data (rd_data_v[g]),
      .m_valid     (m_valid_v[g]),
      .m_ready     (m_ready_v[g]),
      .m_data      (m_data_v[g]),
      .m_last      (m_last_v[g])
`ifdef RAM_RD_STREAM_STALL_CNT_EN
      ,
      .stall_cnt   (stall_v[g])
`endif
    );
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  int sel             = 0;
  int beats           = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc     = -1;
  int exp_done_cyc    = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid_v[sel] && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid_v[sel] && m_ready_v[sel]) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("m_data", 32'(m_data_v[sel]), 32'(mon_e[DW-1:0]));
          chk("m_last", 32'(m_last_v[sel]), 32'(mon_e[DW]));
        end
        beats++;
        if (m_last_v[sel]) begin
          last_hs_cyc  = cyc;
          exp_done_cyc = cyc + 1;
        end
      end
      if (done_v[sel] || cyc == exp_done_cyc)
        chk("done", 32'(done_v[sel]), 32'(cyc == exp_done_cyc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; s returns cyc for the first cycle after
  // the start edge.
  task automatic kick(input int d, input logic [AW-1:0] a, input logic [AW:0] n,
                      input bit expect_it, output int s);
    logic [DW:0]   e;
    logic [AW-1:0] ad;
    sel        = d;
    start_v[d] = 1'b1;
    start_addr = a;
    len        = n;
    if (expect_it) begin
      first_valid_cyc = -1;
      for (int i = 0; i < int'(n); i++) begin
        ad         = a + AW'(i);
        e[DW-1:0]  = mem[ad];
        e[DW]      = (i == int'(n) - 1);
        exp_q.push_back(e);
      end
    end
    tick();
    s       = cyc;
    start_v = '0;
    if (expect_it && n == '0) exp_done_cyc = s + 1;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((busy_v[d] || exp_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("busy_end", 32'(busy_v[d]), 0);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int target, input string tag);
    int n = 0;
    while (beats < target && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(beats >= target), 1);
  endtask

  task automatic chk_reset(input int d);
    chk("rst_busy",    32'(busy_v[d]),    0);
    chk("rst_done",    32'(done_v[d]),    0);
    chk("rst_rd_addr", 32'(rd_addr_v[d]), 0);
    chk("rst_m_valid", 32'(m_valid_v[d]), 0);
    chk("rst_m_data",  32'(m_data_v[d]),  0);
    chk("rst_m_last",  32'(m_last_v[d]),  0);
  endtask

  // Hold m_ready low after beat 3 long enough for issue to stop on credit;
  // the address then sits on the next unissued word.
  task automatic bp_test(input int d);
    int s, b0, p;
    b0 = beats;
    kick(d, 10'h010, 11'd16, 1, s);
    wait_beats(b0 + 4, "bp_beats");
    chk("bp_latency", 32'(first_valid_cyc - s), 32'(d + 2));
    m_ready_v[d] = 1'b0;
    p = beats - b0;
    repeat (10) tick();
    chk("bp_credit_addr", 32'(rd_addr_v[d]), 32'(16 + p + (d + 1) + 1));
    m_ready_v[d] = 1'b1;
    wait_idle(d);
  endtask

  task automatic rand_test(input int d);
    int s, n;
    logic [AW-1:0] a;
    logic [AW:0]   l;
    a = AW'($urandom_range(0, (1 << AW) - 1));
    l = (AW + 1)'($urandom_range(1, 24));
    kick(d, a, l, 1, s);
    n = 0;
    while ((busy_v[d] || exp_q.size() != 0) && n < 400) begin
      m_ready_v[d] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready_v[d] = 1'b1;
    wait_idle(d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s, b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
    rst_n      = 1'b0;
    start_v    = '0;
    start_addr = '0;
    len        = '0;
    m_ready_v  = 2'b11;
    repeat (3) tick();
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    tick();

    // Basic four-beat read, latency 1.
    kick(0, 10'h010, 11'd4, 1, s);
    wait_idle(0);
    chk("lat1_first_valid", 32'(first_valid_cyc - s), 2);
    chk("lat1_back_to_back", 32'(last_hs_cyc - first_valid_cyc), 3);

    // Backpressure and credit limit at both latencies.
    bp_test(0);
    bp_test(1);

    // Random backpressure.
    for (int r = 0; r < 3; r++) rand_test(1);
    for (int r = 0; r < 3; r++) rand_test(0);

    // Address wrap.
    kick(0, 10'h3FE, 11'd4, 1, s);
    wait_idle(0);
    chk("wrap_final_addr", 32'(rd_addr_v[0]), 32'h001);

    // Zero-length command.
    kick(0, 10'h055, 11'd0, 1, s);
    chk("len0_busy_c1", 32'(busy_v[0]), 1);
    tick();
    chk("len0_busy_c2", 32'(busy_v[0]), 0);
    repeat (4) tick();
    chk("len0_no_valid", 32'(first_valid_cyc < 0), 1);

    // Start while busy is ignored.
    b0 = beats;
    kick(0, 10'h020, 11'd8, 1, s);
    tick();
    tick();
    kick(0, 10'h300, 11'd5, 0, s);
    wait_idle(0);
    chk("ignored_start_beats", 32'(beats - b0), 8);

    // Reset in the middle of a burst.
    b0 = beats;
    kick(0, 10'h040, 11'd8, 1, s);
    wait_beats(b0 + 2, "rst_mid_beats");
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    kick(0, 10'h080, 11'd4, 1, s);
    wait_idle(0);
    chk("post_rst_first_valid", 32'(first_valid_cyc - s), 2);

`ifdef RAM_RD_STREAM_STALL_CNT_EN
    m_ready_v[0] = 1'b0;
    kick(0, 10'h100, 11'd8, 1, s);
    for (int n = 0; n < 50 && !m_valid_v[0]; n++) tick();
    chk("stall_valid_seen", 32'(m_valid_v[0]), 1);
    repeat (5) tick();
    m_ready_v[0] = 1'b1;
    wait_idle(0);
    chk("stall_cnt", 32'(stall_v[0]), 5);
    kick(0, 10'h108, 11'd1, 1, s);
    chk("stall_clear", 32'(stall_v[0]), 0);
    wait_idle(0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
